// File: rtl/wishbone_ram_responder_if.sv
// Wishbone classic-cycle bus bundle between a load/store master and the
// RAM responder.
//   master modport: drives cyc/stb/we/adr/sel/dat_w/cti/bte, receives dat_r/ack/err
//   slave  modport: the mirror image
interface wishbone_ram_responder_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, sel, dat_w, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wishbone_ram_responder.sv
// Wishbone classic-cycle responder in front of a word-addressed RAM.
// Byte-select writes, WAIT_STATES extra cycles before the response, and an
// err (or ack with dropped write / zero read data) for out-of-window accesses.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   wb   - Wishbone slave port (cyc/stb/we/adr/sel/dat_w/cti/bte in,
//          dat_r/ack/err out, all outputs registered)
module wishbone_ram_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter bit          INCLUDE_ERR = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  wishbone_ram_responder_if.slave   wb
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     dat_w_q, dat_w_d;
  logic            in_range_q, in_range_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]     dat_r_q, dat_r_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            ram_we;

  logic [31:0]     mem [DEPTH_WORDS];

  // Window decode: the subtraction wraps for addresses below BASE_ADDR, so a
  // single unsigned compare covers both ends of the window.
  logic [31:0] off;
  logic        in_range;
  assign off      = wb.adr - BASE_ADDR;
  assign in_range = off < 32'(4 * DEPTH_WORDS);

  // Classic cycles only: burst hints and the sub-word/out-of-window offset
  // bits carry no information for this target.
  logic unused_bits;
  assign unused_bits = ^{wb.cti, wb.bte, off[1:0], off[31:AW+2]};

  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    we_d       = we_q;
    sel_d      = sel_q;
    dat_w_d    = dat_w_q;
    in_range_d = in_range_q;
    wait_cnt_d = wait_cnt_q;
    dat_r_d    = dat_r_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ram_we     = 1'b0;
    case (state_q)
      IDLE: begin
        // cyc held with stb low is an idle hold, nothing to do
        if (wb.cyc && wb.stb) begin
          widx_d     = off[AW+1:2];
          we_d       = wb.we;
          sel_d      = wb.sel;
          dat_w_d    = wb.dat_w;
          in_range_d = in_range;
          wait_cnt_d = 4'(WAIT_STATES);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!wb.cyc) begin
          // master abandoned the cycle: no side effects, no termination
          state_d = IDLE;
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (in_range_q) begin
            ack_d = 1'b1;
            if (we_q) ram_we = 1'b1;
            else      dat_r_d = mem[widx_q];
          end else if (INCLUDE_ERR) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (!we_q) dat_r_d = '0;
          end
        end
      end
      RESP: begin
        // termination is one cycle wide; stb is deliberately not looked at
        // here so the master has this cycle to drop it
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      widx_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_w_q    <= '0;
      in_range_q <= 1'b0;
      wait_cnt_q <= '0;
      dat_r_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      dat_w_q    <= dat_w_d;
      in_range_q <= in_range_d;
      wait_cnt_q <= wait_cnt_d;
      dat_r_q    <= dat_r_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // RAM contents are never reset; a reset edge only suppresses a pending write.
  // The read address comes from widx_q, so reads behave as a synchronous RAM.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      for (int i = 0; i < 4; i++)
        if (sel_q[i]) mem[widx_q][8*i +: 8] <= dat_w_q[8*i +: 8];
    end
  end

  assign wb.dat_r = dat_r_q;
  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
endmodule

// File: doc/wishbone_ram_responder.md
# wishbone_ram_responder

Wishbone classic-cycle responder that fronts a word-addressed synchronous block RAM, with byte-select writes, configurable wait states and an error response for out-of-window addresses. It sits on the external data/peripheral bus as the target for the core's load/store Wishbone master. It tolerates the master holding `cyc` across back-to-back requests, including LR reservation holds. It also tolerates the master abandoning a cycle before it is acknowledged.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: byte base of the decoded window; aligned to `4*DEPTH_WORDS`.
- `WAIT_STATES`, 0: extra cycles inserted before the response; range 0–15.
- `INCLUDE_ERR`, 1: 1 = out-of-window access answers `err`; 0 = answers `ack`, with read data 0 and the write dropped.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `cyc` in 1: bus cycle active.
- `stb` in 1: request strobe.
- `we` in 1: 1 = write.
- `adr` in 32: byte address; `adr[1:0]` ignored.
- `sel` in 4: byte lane enables; honoured on writes, ignored on reads.
- `dat_w` in 32: write data.
- `cti` in 3, `bte` in 2: accepted and ignored (classic cycles only).
- `dat_r` out 32: read data, registered.
- `ack` out 1: normal termination, registered.
- `err` out 1: error termination, registered.

## Operation
- `in_range` = (`adr` − `BASE_ADDR`) < 4·`DEPTH_WORDS`, compared as 32-bit unsigned.
- Word index = (`adr` − `BASE_ADDR`)[log2(4·DEPTH)-1:2].
- State machine states: IDLE, ACCESS, RESP.
- IDLE:
  - On `cyc & stb`: latch `adr`, `we`, `sel`, `dat_w` and `in_range`; load `wait_cnt` = `WAIT_STATES`; go to ACCESS.
  - Otherwise stay in IDLE.
  - `cyc` high with `stb` low is legal (held cycle); no action.
- ACCESS: on each edge the actions below are taken in priority order.
  - If `cyc` is low (abort): go to IDLE. No RAM write, no `ack`/`err`.
  - Else if `wait_cnt` ≠ 0: decrement `wait_cnt`.
  - Else (`wait_cnt` = 0): perform the access and go to RESP.
    - In range, write: update RAM bytes where `sel[i]`=1; other bytes keep their value. `ack`<=1. `dat_r` unchanged.
    - In range, read: `dat_r` <= full RAM word. `ack`<=1.
    - Out of range, `INCLUDE_ERR`=1: `err`<=1. No write; `dat_r` unchanged.
    - Out of range, `INCLUDE_ERR`=0: `ack`<=1. Write dropped; a read sets `dat_r` <= 0.
- RESP: `ack`<=0, `err`<=0; go to IDLE. `stb` is not sampled in RESP.
- Exactly one of `ack`/`err` is asserted per accepted request, and never both.
- `dat_r` holds its last value between reads.

## Timing
- Reset: state IDLE, `ack`=0, `err`=0, `dat_r`=0, `wait_cnt`=0. RAM contents are not reset.
- Reset mid-operation: any ACCESS/RESP state is abandoned. No write occurs, and no `ack`/`err` is issued after reset.
- Latency: request first visible in cycle 0 → `ack`/`err` high in cycle 2+`WAIT_STATES`, for exactly one cycle.
- `dat_r` is valid in the same cycle as `ack`.
- Write effect: data becomes visible on the edge that raises `ack`. A read accepted afterwards returns the new data.
- Handshake: the master drops `stb` on the edge after it samples `ack`. IDLE then sees `stb`=0, so there is no double acceptance.
- Back-to-back: next request accepted at the earliest in cycle 3+`WAIT_STATES`. Sustained throughput is one transfer per 3+`WAIT_STATES` cycles.
- Held `cyc`: `cyc` high with `stb` low for any number of cycles does not alter state or outputs.
- Abort: `cyc` low on any ACCESS edge, including the final one where `wait_cnt`=0, cancels the access; next state is IDLE.

## Test plan
- Read after write, `WAIT_STATES`=0, `BASE_ADDR`=0x1000:
  - Write 0xDEADBEEF to 0x1008 with `sel`=4'hF → `ack` in cycle 2.
  - Read 0x1008 → `ack` in cycle 2 with `dat_r`=0xDEADBEEF.
- Byte lanes:
  - Preload 0x11223344, then write 0xAABBCCDD with `sel`=4'b0101.
  - Read → 0x11BB33DD.
- Wait states, `WAIT_STATES`=3: read request → `ack` exactly in cycle 5, high for one cycle; `err`=0 throughout.
- Out of range:
  - With `INCLUDE_ERR`=1, write to `BASE_ADDR`+4·`DEPTH_WORDS` → `err` in cycle 2 and `ack`=0; a read of word 0 is unchanged.
  - With `INCLUDE_ERR`=0, a read of that address → `ack` with `dat_r`=0.
- Abort and reset, `WAIT_STATES`=4:
  - Write request, then `cyc` dropped in cycle 2 → no `ack`, and the RAM word keeps its old value.
  - Repeat with `rst` pulsed in cycle 3 → same result; next request is acknowledged normally.
- Held cycle: `cyc` held high for 32 idle cycles between a read and an LR-style read of the same address → both `ack` with correct data; no spurious `ack`/`err` during the hold.
